// File: rtl/rtc_multi.sv
// rtl/rtc_multi.sv - multi-channel periodic/one-shot interrupt timer
// Shared prescaler tick drives per-channel counters with held interrupts and sticky overrun flags.
module rtc_multi #(
  parameter int CHANNELS       = 4,
  parameter int CNT_SIZE       = 16,
  parameter int PRESC_SIZE     = 8,
  parameter int PERIOD_DEFAULT = 0,
  parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_i,
  input  logic [CH_W-1:0]     ch_sel_i,
  input  logic [1:0]          reg_sel_i,
  input  logic [CNT_SIZE-1:0] data_i,
  output logic [CNT_SIZE-1:0] data_o,
  output logic [CHANNELS-1:0] int_o,
  input  logic [CHANNELS-1:0] int_ack_i
);

  localparam logic [1:0]          REG_PERIOD = 2'd0;
  localparam logic [1:0]          REG_CTRL   = 2'd1;
  localparam logic [1:0]          REG_PRESC  = 2'd2;
  localparam logic [CNT_SIZE-1:0] PERIOD_RST = CNT_SIZE'(PERIOD_DEFAULT);
  localparam logic                EN_RST     = (PERIOD_DEFAULT != 0);

  logic [PRESC_SIZE-1:0] presc;
  logic [PRESC_SIZE-1:0] pre_cnt;
  logic                  tick;
  logic                  presc_wr;
  logic [CNT_SIZE-1:0]   period [CHANNELS];
  logic [CNT_SIZE-1:0]   cnt    [CHANNELS];
  logic [CHANNELS-1:0]   en;
  logic [CHANNELS-1:0]   oneshot;
  logic [CHANNELS-1:0]   ovr;
  logic [CHANNELS-1:0]   per_wr;
  logic [CHANNELS-1:0]   ctl_wr;
  logic [CHANNELS-1:0]   wrap;
  logic [CHANNELS-1:0]   evt;

  assign tick     = (pre_cnt == presc);
  assign presc_wr = wr_i && (reg_sel_i == REG_PRESC);

  // A PERIOD write in the same cycle suppresses the event so the new period starts clean.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      per_wr[i] = wr_i && (ch_sel_i == CH_W'(i)) && (reg_sel_i == REG_PERIOD);
      ctl_wr[i] = wr_i && (ch_sel_i == CH_W'(i)) && (reg_sel_i == REG_CTRL);
      wrap[i]   = (cnt[i] >= period[i] - CNT_SIZE'(1));
      evt[i]    = tick && en[i] && (period[i] != '0) && wrap[i] && !per_wr[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc   <= '0;
      pre_cnt <= '0;
      int_o   <= '0;
      en      <= {CHANNELS{EN_RST}};
      oneshot <= '0;
      ovr     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        period[i] <= PERIOD_RST;
        cnt[i]    <= '0;
      end
    end else begin
      if (presc_wr) begin
        presc   <= data_i[PRESC_SIZE-1:0];
        pre_cnt <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PRESC_SIZE'(1);
      end

      for (int i = 0; i < CHANNELS; i++) begin
        if (per_wr[i]) begin
          period[i] <= data_i;
          cnt[i]    <= '0;
        end else if (ctl_wr[i] && data_i[0] && !en[i]) begin
          cnt[i] <= '0;
        end else if (period[i] == '0) begin
          cnt[i] <= '0;
        end else if (tick && en[i]) begin
          cnt[i] <= wrap[i] ? '0 : cnt[i] + CNT_SIZE'(1);
        end

        // A fresh event replaces an acknowledged one, so the line stays high.
        if (evt[i]) begin
          int_o[i] <= 1'b1;
        end else if (int_ack_i[i]) begin
          int_o[i] <= 1'b0;
        end

        if (ctl_wr[i] && data_i[2]) begin
          ovr[i] <= 1'b0;
        end
        if (evt[i] && int_o[i] && !int_ack_i[i]) begin
          ovr[i] <= 1'b1;
        end

        if (ctl_wr[i]) begin
          en[i]      <= data_i[0];
          oneshot[i] <= data_i[1];
        end else if (evt[i] && oneshot[i]) begin
          en[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    data_o = '0;
    if (reg_sel_i == REG_PRESC) begin
      data_o = CNT_SIZE'(presc);
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_sel_i == CH_W'(i)) begin
          case (reg_sel_i)
            REG_PERIOD: data_o = period[i];
            REG_CTRL:   data_o[2:0] = {ovr[i], oneshot[i], en[i]};
            default:    data_o = cnt[i];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_multi.sv
// tb/tb_rtc_multi.sv - directed and randomized bench for rtc_multi
// Reference model tracks elapsed ticks per channel and derives counts and events by modulo arithmetic.
module tb_rtc_multi;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        wr      = 1'b0;
  logic [1:0]  ch_sel  = '0;
  logic [1:0]  reg_sel = '0;
  logic [15:0] data    = '0;
  logic [15:0] data_o;
  logic [3:0]  int_o;
  logic [3:0]  ack     = '0;

  int vec  = 0;
  int miss = 0;

  int        m_presc;
  int        m_pcyc;
  int        m_period [4];
  int        m_ticks  [4];
  bit  [3:0] m_en;
  bit  [3:0] m_one;
  bit  [3:0] m_ovr;
  logic [3:0] m_int;

  bit        auto_en  = 1'b1;
  logic [3:0] auto_ack = '0;
  int        lat;

  rtc_multi #(
    .CHANNELS(4), .CNT_SIZE(16), .PRESC_SIZE(8), .PERIOD_DEFAULT(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .ch_sel_i(ch_sel), .reg_sel_i(reg_sel),
    .data_i(data), .data_o(data_o), .int_o(int_o), .int_ack_i(ack)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_presc = 0;
    m_pcyc  = 0;
    m_en    = '0;
    m_one   = '0;
    m_ovr   = '0;
    m_int   = '0;
    for (int i = 0; i < 4; i++) begin
      m_period[i] = 0;
      m_ticks[i]  = 0;
    end
  endfunction

  function automatic void model_next();
    bit tick, pw, cw, ev;
    tick = ((m_pcyc % (m_presc + 1)) == m_presc);
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      pw = wr && (int'(ch_sel) == i) && (reg_sel == 2'd0);
      cw = wr && (int'(ch_sel) == i) && (reg_sel == 2'd1);
      ev = tick && m_en[i] && (m_period[i] != 0) && (((m_ticks[i] + 1) % m_period[i]) == 0) && !pw;
      if (pw) begin
        m_period[i] = int'(data);
        m_ticks[i]  = 0;
      end else if (cw && data[0] && !m_en[i]) begin
        m_ticks[i] = 0;
      end else if (tick && m_en[i] && (m_period[i] != 0)) begin
        m_ticks[i]++;
      end
      if (cw && data[2]) m_ovr[i] = 1'b0;
      if (ev && m_int[i] && !ack[i]) m_ovr[i] = 1'b1;
      if (ev) m_int[i] = 1'b1;
      else if (ack[i]) m_int[i] = 1'b0;
      if (cw) begin
        m_en[i]  = data[0];
        m_one[i] = data[1];
      end else if (ev && m_one[i]) begin
        m_en[i] = 1'b0;
      end
    end
    if (wr && reg_sel == 2'd2) begin
      m_presc = int'(data[7:0]);
      m_pcyc  = 0;
    end else begin
      m_pcyc++;
    end
  endfunction

  function automatic logic [15:0] model_read();
    int c;
    c = int'(ch_sel);
    case (reg_sel)
      2'd0:    return 16'(m_period[c]);
      2'd1:    return {13'b0, m_ovr[c], m_one[c], m_en[c]};
      2'd2:    return 16'(m_presc);
      default: return (m_period[c] == 0) ? 16'd0 : 16'(m_ticks[c] % m_period[c]);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    if (auto_en) ack = m_int & auto_ack;
    model_next();
    @(posedge clk);
    #1;
    chk("int_o", 16'(int_o), 16'(m_int));
    chk("data_o", data_o, model_read());
  endtask

  task automatic wreg(input int c, input int r, input int d);
    wr      = 1'b1;
    ch_sel  = 2'(c);
    reg_sel = 2'(r);
    data    = 16'(d);
    step();
    wr = 1'b0;
  endtask

  task automatic rd(input string tag, input int c, input int r, input int exp);
    wr      = 1'b0;
    ch_sel  = 2'(c);
    reg_sel = 2'(r);
    #1;
    chk(tag, data_o, 16'(exp));
  endtask

  initial begin
    model_reset();

    // reset state and idle behaviour
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_int", 16'(int_o), 16'd0);
    for (int c = 0; c < 4; c++) begin
      rd("rst_period", c, 0, 0);
      rd("rst_ctrl", c, 1, 0);
      rd("rst_count", c, 3, 0);
      step();
    end
    rd("rst_presc", 0, 2, 0);
    auto_en = 1'b0;
    for (int k = 0; k < 100; k++) begin
      ack     = 4'($urandom);
      ch_sel  = 2'($urandom);
      reg_sel = 2'($urandom);
      step();
    end
    auto_en = 1'b1;
    chk("idle_int", 16'(int_o), 16'd0);

    // ch0 periodic, period 5, acked every time
    wreg(0, 2, 0);
    wreg(0, 0, 5);
    wreg(0, 1, 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("p5_first", 16'(int_o[0]), 16'(k == 5));
    end
    auto_ack = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("p5_pulse", 16'(int_o[0]), 16'((k % 5) == 0));
    end
    rd("p5_ovr_clear", 0, 1, 1);
    wreg(0, 1, 0);
    step();
    auto_ack = '0;

    // ch1 with prescaler 3, unacked -> overrun
    wreg(0, 2, 3);
    wreg(1, 0, 4);
    wreg(1, 1, 1);
    lat = 0;
    while (lat < 20) begin
      step();
      lat++;
      if (int_o[1]) break;
    end
    chk("presc_latency", 16'(lat >= 13 && lat <= 16), 16'd1);
    repeat (16) step();
    rd("presc_ovr_set", 1, 1, 5);
    wreg(1, 1, 5);
    rd("presc_ovr_cleared", 1, 1, 1);
    auto_ack = 4'b0010;
    wreg(1, 1, 0);
    auto_ack = '0;

    // ch2 one-shot
    wreg(0, 2, 0);
    wreg(2, 0, 3);
    wreg(2, 1, 3);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("oneshot_int", 16'(int_o[2]), 16'(k >= 3));
    end
    rd("oneshot_count", 2, 3, 0);
    rd("oneshot_ctrl", 2, 1, 2);
    auto_ack = 4'b0100;
    step();
    auto_ack = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("oneshot_quiet", 16'(int_o[2]), 16'd0);
    end

    // period rewrite coinciding with the wrapping tick
    wreg(0, 0, 5);
    wreg(0, 1, 1);
    repeat (4) step();
    rd("rewrite_cnt4", 0, 3, 4);
    wreg(0, 0, 10);
    chk("rewrite_no_evt", 16'(int_o[0]), 16'd0);
    rd("rewrite_cnt0", 0, 3, 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("rewrite_next", 16'(int_o[0]), 16'(k == 10));
    end
    auto_ack = 4'b0001;
    wreg(0, 1, 0);
    auto_ack = '0;

    // ack colliding with event, overrun set-wins, period 1 streaming
    wreg(0, 0, 2);
    wreg(0, 1, 1);
    step();
    step();
    chk("coll_rise", 16'(int_o[0]), 16'd1);
    step();
    auto_ack = 4'b0001;
    step();
    auto_ack = '0;
    chk("coll_int_held", 16'(int_o[0]), 16'd1);
    rd("coll_ovr_kept", 0, 1, 1);
    step();
    step();
    rd("coll_ovr_set", 0, 1, 5);
    wreg(0, 0, 1);
    wreg(0, 1, 5);
    rd("ovr_set_wins", 0, 1, 5);
    auto_ack = 4'b0001;
    wreg(0, 1, 5);
    rd("ovr_clear_acked", 0, 1, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("p1_stream", 16'(int_o[0]), 16'd1);
    end
    rd("p1_no_ovr", 0, 1, 1);
    auto_ack = '0;

    // reset in the middle of counting
    wreg(3, 0, 7);
    wreg(3, 1, 1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_int", 16'(int_o), 16'd0);
    rd("midrst_count", 3, 3, 0);
    rd("midrst_ctrl", 0, 1, 0);
    rd("midrst_period", 3, 0, 0);
    rd("midrst_presc", 0, 2, 0);

    // randomized soak against the model
    auto_en = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom_range(0, 199) == 0);
      wr      = ($urandom_range(0, 3) == 0);
      ch_sel  = 2'($urandom);
      reg_sel = 2'($urandom);
      case (reg_sel)
        2'd0:    data = 16'($urandom_range(0, 9));
        2'd1:    data = 16'($urandom_range(0, 7));
        2'd2:    data = 16'($urandom_range(0, 3));
        default: data = 16'($urandom);
      endcase
      ack = 4'($urandom);
      step();
    end
    rst = 1'b0;
    wr  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
